// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared digit width and per-digit next-value / terminal helpers
//                for the cascaded modulo-N counter chain.
//  Revision    : 1.0  initial release
// ============================================================================
package counter_pkg;

    localparam int DIGIT_W = 4;

    // Out-of-range codes read as "not a legal digit": they clear on load and on step.
    function automatic logic [DIGIT_W-1:0] sanitize(input logic [DIGIT_W-1:0] val,
                                                    input int unsigned         modulus);
        int unsigned v;
        v = {28'd0, val};
        if (v >= modulus) begin
            return '0;
        end
        return val;
    endfunction

    // Next value of a single digit when it is told to step.
    function automatic logic [DIGIT_W-1:0] digit_next(input logic [DIGIT_W-1:0] val,
                                                      input logic                up,
                                                      input int unsigned         modulus);
        int unsigned v;
        int unsigned n;
        v = {28'd0, val};
        if (v >= modulus) begin
            n = 0;
        end else if (up) begin
            n = (v == modulus - 1) ? 0 : v + 1;
        end else begin
            n = (v == 0) ? modulus - 1 : v - 1;
        end
        return DIGIT_W'(n);
    endfunction

    // An illegal digit is never terminal, so it can never start a carry/borrow.
    function automatic logic is_terminal(input logic [DIGIT_W-1:0] val,
                                         input logic                up,
                                         input int unsigned         modulus);
        int unsigned v;
        v = {28'd0, val};
        if (v >= modulus) begin
            return 1'b0;
        end
        return up ? (v == modulus - 1) : (v == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter_chain_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_counter_chain_if
//  Description : Control / count bundle of the counter chain. The master side
//                drives enable, direction and load; the slave side returns the
//                count, terminal count and wrap pulse.
//  Revision    : 1.0  initial release
// ============================================================================
interface bcd_counter_chain_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  en;
    logic                  up_dn;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   q;
    logic                  tc;
    logic                  wrap;

    modport master (
        output en,
        output up_dn,
        output load,
        output load_val,
        input  q,
        input  tc,
        input  wrap
    );

    modport slave (
        input  en,
        input  up_dn,
        input  load,
        input  load_val,
        output q,
        output tc,
        output wrap
    );
endinterface
`default_nettype wire

// File: rtl/counter_digit.sv
`default_nettype none
// ============================================================================
//  Module      : counter_digit
//  Description : One modulo-MODULUS digit of the chain. Loads a sanitised
//                value or steps in the requested direction; flags when it
//                sits at the terminal value for that direction.
//  Revision    : 1.0  initial release
// ============================================================================
module counter_digit
    import counter_pkg::*;
#(
    parameter int unsigned MODULUS = 10
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               step,
    input  wire logic               up_dn,
    input  wire logic               load,
    input  wire logic [DIGIT_W-1:0] load_d,
    output logic      [DIGIT_W-1:0] d,
    output logic                    at_term
);

    logic [DIGIT_W-1:0] r_d;

    // Digit register: load beats step, both beat hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d <= '0;
        end else if (load) begin
            r_d <= sanitize(load_d, MODULUS);
        end else if (step) begin
            r_d <= digit_next(r_d, up_dn, MODULUS);
        end
    end

    assign d       = r_d;
    assign at_term = is_terminal(r_d, up_dn, MODULUS);

endmodule
`default_nettype wire

// File: rtl/bcd_counter_chain.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_counter_chain
//  Description : DIGITS cascaded modulo-MODULUS up/down digits on one clock.
//                Carries are computed as a synchronous lookahead chain, so
//                every digit sees the same edge. Combinational terminal count
//                and a registered one-cycle wrap pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_counter_chain
    import counter_pkg::*;
#(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned MODULUS = 10
) (
    input  wire logic          clk,
    input  wire logic          reset,
    bcd_counter_chain_if.slave bus
);

    logic [DIGITS-1:0]         w_step;
    logic [DIGITS-1:0]         w_at_term;
    logic [DIGIT_W*DIGITS-1:0] w_q;
    logic                      r_wrap;

    // Digit 0 steps on every enabled cycle; digit k needs all lower digits terminal.
    assign w_step[0] = bus.en;

    generate
        for (genvar k = 1; k < DIGITS; k++) begin : g_step
            assign w_step[k] = w_step[k-1] & w_at_term[k-1];
        end

        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            counter_digit #(
                .MODULUS (MODULUS)
            ) u_digit (
                .clk     (clk),
                .reset   (reset),
                .step    (w_step[k]),
                .up_dn   (bus.up_dn),
                .load    (bus.load),
                .load_d  (bus.load_val[DIGIT_W*k +: DIGIT_W]),
                .d       (w_q[DIGIT_W*k +: DIGIT_W]),
                .at_term (w_at_term[k])
            );
        end
    endgenerate

    // tc already excludes load, so registering it marks exactly the full-chain wrap edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= bus.tc;
        end
    end

    assign bus.tc   = bus.en & ~bus.load & (&w_at_term);
    assign bus.q    = w_q;
    assign bus.wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_chain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_counter_chain
//  Description : Self-checking bench for two counter chains (4 x BCD and
//                2 x hex nibbles) against an integer reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_counter_chain;

    logic clk;
    logic rst_a_n;
    logic rst_b_n;

    int n_checks;
    int n_errors;

    // Reference model: count held as an integer in [0, MODULUS**DIGITS).
    longint unsigned m_val  [2];
    bit              m_wrap [2];
    int              c_mod  [2] = '{10, 16};
    int              c_dig  [2] = '{4, 2};

    bcd_counter_chain_if #(.DIGITS(4)) if_a ();
    bcd_counter_chain_if #(.DIGITS(2)) if_b ();

    bcd_counter_chain #(
        .DIGITS  (4),
        .MODULUS (10)
    ) u_dut_a (
        .clk   (clk),
        .reset (rst_a_n),
        .bus   (if_a)
    );

    bcd_counter_chain #(
        .DIGITS  (2),
        .MODULUS (16)
    ) u_dut_b (
        .clk   (clk),
        .reset (rst_b_n),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint unsigned span(input int i);
        longint unsigned r;
        r = 1;
        for (int k = 0; k < c_dig[i]; k++) r = r * longint'(c_mod[i]);
        return r;
    endfunction

    // Value a load produces: out-of-range fields become zero.
    function automatic longint unsigned load_value(input int i, input logic [31:0] lv);
        longint unsigned v;
        longint unsigned mul;
        int              f;
        v   = 0;
        mul = 1;
        for (int k = 0; k < c_dig[i]; k++) begin
            f = int'(lv[4*k +: 4]);
            if (f >= c_mod[i]) f = 0;
            v   = v + longint'(f) * mul;
            mul = mul * longint'(c_mod[i]);
        end
        return v;
    endfunction

    function automatic logic [31:0] to_q(input int i, input longint unsigned val);
        logic [31:0]     q;
        longint unsigned v;
        q = '0;
        v = val;
        for (int k = 0; k < c_dig[i]; k++) begin
            q[4*k +: 4] = 4'(v % longint'(c_mod[i]));
            v = v / longint'(c_mod[i]);
        end
        return q;
    endfunction

    function automatic logic exp_tc(input int i, input logic en, input logic up, input logic ld);
        if (!en || ld) return 1'b0;
        return up ? (m_val[i] == span(i) - 1) : (m_val[i] == 0);
    endfunction

    task automatic model_step(input int i, input logic rst_n, input logic en, input logic up,
                              input logic ld, input logic [31:0] lv);
        longint unsigned n;
        n = span(i);
        if (!rst_n) begin
            m_val[i]  = 0;
            m_wrap[i] = 1'b0;
        end else if (ld) begin
            m_val[i]  = load_value(i, lv);
            m_wrap[i] = 1'b0;
        end else if (en) begin
            if (up) begin
                m_wrap[i] = (m_val[i] == n - 1);
                m_val[i]  = (m_val[i] + 1) % n;
            end else begin
                m_wrap[i] = (m_val[i] == 0);
                m_val[i]  = (m_val[i] + n - 1) % n;
            end
        end else begin
            m_wrap[i] = 1'b0;
        end
    endtask

    // One clock: tc checked mid-cycle, q/wrap checked just after the edge.
    task automatic tick();
        @(negedge clk);
        check("tc_a", {31'd0, if_a.tc}, {31'd0, exp_tc(0, if_a.en, if_a.up_dn, if_a.load)});
        check("tc_b", {31'd0, if_b.tc}, {31'd0, exp_tc(1, if_b.en, if_b.up_dn, if_b.load)});
        model_step(0, rst_a_n, if_a.en, if_a.up_dn, if_a.load, {16'd0, if_a.load_val});
        model_step(1, rst_b_n, if_b.en, if_b.up_dn, if_b.load, {24'd0, if_b.load_val});
        @(posedge clk);
        #1;
        check("q_a",    {16'd0, if_a.q},    to_q(0, m_val[0]));
        check("wrap_a", {31'd0, if_a.wrap}, {31'd0, m_wrap[0]});
        check("q_b",    {24'd0, if_b.q},    to_q(1, m_val[1]));
        check("wrap_b", {31'd0, if_b.wrap}, {31'd0, m_wrap[1]});
    endtask

    task automatic drive_a(input logic en, input logic up, input logic ld, input logic [15:0] lv);
        if_a.en       = en;
        if_a.up_dn    = up;
        if_a.load     = ld;
        if_a.load_val = lv;
    endtask

    task automatic drive_b(input logic en, input logic up, input logic ld, input logic [7:0] lv);
        if_b.en       = en;
        if_b.up_dn    = up;
        if_b.load     = ld;
        if_b.load_val = lv;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        m_val[0]  = 0;
        m_val[1]  = 0;
        m_wrap[0] = 1'b0;
        m_wrap[1] = 1'b0;
        rst_a_n   = 1'b0;
        rst_b_n   = 1'b0;
        drive_a(1'b1, 1'b1, 1'b1, 16'h1234);
        drive_b(1'b1, 1'b1, 1'b1, 8'h5A);

        // Reset held with load and en active.
        for (int c = 0; c < 3; c++) tick();
        check("rst_q_a", {16'd0, if_a.q}, 32'h0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        drive_a(1'b1, 1'b1, 1'b0, 16'h0);
        drive_b(1'b0, 1'b1, 1'b0, 8'h0);
        for (int c = 0; c < 3; c++) tick();
        check("release_q_a", {16'd0, if_a.q}, 32'h0003);

        // BCD carry across several digits, then full-chain wrap up.
        drive_a(1'b0, 1'b1, 1'b1, 16'h0998); tick();
        drive_a(1'b1, 1'b1, 1'b0, 16'h0);
        for (int c = 0; c < 3; c++) tick();
        check("carry_q_a", {16'd0, if_a.q}, 32'h1001);
        drive_a(1'b0, 1'b1, 1'b1, 16'h9999); tick();
        drive_a(1'b1, 1'b1, 1'b0, 16'h0);
        for (int c = 0; c < 3; c++) tick();

        // Borrow and full-chain wrap down.
        drive_a(1'b0, 1'b0, 1'b1, 16'h1000); tick();
        drive_a(1'b1, 1'b0, 1'b0, 16'h0);
        for (int c = 0; c < 2; c++) tick();
        check("borrow_q_a", {16'd0, if_a.q}, 32'h0998);
        drive_a(1'b0, 1'b0, 1'b1, 16'h0000); tick();
        drive_a(1'b1, 1'b0, 1'b0, 16'h0);
        for (int c = 0; c < 3; c++) tick();

        // Load wins over en; illegal fields sanitised; hold with en low.
        drive_a(1'b1, 1'b1, 1'b1, 16'h0A3F); tick();
        check("sanitize_q_a", {16'd0, if_a.q}, 32'h0030);
        drive_a(1'b0, 1'b1, 1'b0, 16'h0);
        for (int c = 0; c < 5; c++) tick();

        // Direction flip.
        drive_a(1'b0, 1'b1, 1'b1, 16'h0419); tick();
        drive_a(1'b1, 1'b0, 1'b0, 16'h0); tick();
        check("flip_q_a", {16'd0, if_a.q}, 32'h0418);

        // Async reset between edges.
        drive_a(1'b0, 1'b1, 1'b1, 16'h0510); tick();
        drive_a(1'b1, 1'b1, 1'b0, 16'h0);
        for (int c = 0; c < 7; c++) tick();
        check("pre_rst_q_a", {16'd0, if_a.q}, 32'h0517);
        #2;
        rst_a_n   = 1'b0;
        m_val[0]  = 0;
        m_wrap[0] = 1'b0;
        #1;
        check("async_q_a",    {16'd0, if_a.q},    32'h0);
        check("async_wrap_a", {31'd0, if_a.wrap}, 32'h0);
        tick();
        rst_a_n = 1'b1;
        tick();

        // Hex chain: wrap at FF, direction flip at 05.
        drive_a(1'b0, 1'b1, 1'b0, 16'h0);
        drive_b(1'b0, 1'b1, 1'b1, 8'hFE); tick();
        drive_b(1'b1, 1'b1, 1'b0, 8'h0);
        tick();
        check("hex_ff_q_b", {24'd0, if_b.q}, 32'hFF);
        for (int c = 0; c < 3; c++) tick();
        drive_b(1'b0, 1'b1, 1'b1, 8'h04); tick();
        drive_b(1'b1, 1'b1, 1'b0, 8'h0); tick();
        drive_b(1'b1, 1'b0, 1'b0, 8'h0); tick();
        check("hex_flip_q_b", {24'd0, if_b.q}, 32'h04);

        // Randomised traffic on both chains, biased toward terminal values.
        for (int c = 0; c < 400; c++) begin
            logic [15:0] lva;
            logic [7:0]  lvb;
            case ($urandom_range(0, 3))
                0:       lva = 16'h9999;
                1:       lva = 16'h0000;
                2:       lva = 16'h9990 | 16'($urandom_range(0, 9));
                default: lva = 16'($urandom);
            endcase
            case ($urandom_range(0, 2))
                0:       lvb = 8'hFF;
                1:       lvb = 8'h00;
                default: lvb = 8'($urandom);
            endcase
            drive_a($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) == 0, lva);
            drive_b($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) == 0, lvb);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
